// File: rtl/xor_share_sched.sv
// xor_share_sched: round-robin arbiter that shares one bit-serial XOR cell
// between two requesters.
//
// The granted requester's operands are captured and a single 1-bit XOR
// produces the result LSB-first, one bit per clock. The block returns the
// XOR word, its parity, and the ID of the requester that was served.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   req0/a0/b0     requester 0 request (held until gnt0) and operands
//   req1/a1/b1     requester 1 request (held until gnt1) and operands
//   gnt0/gnt1      one-cycle pulse: operands of that requester captured
//   busy           high while an operation is in RUN or DONE
//   done           one-cycle pulse: result/parity/done_id valid
//   done_id        requester served by the completed operation
//   result         a ^ b of the served requester (held until next done)
//   parity         XOR-reduction of result (held until next done)
module xor_share_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             parity
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // Holds the bits produced so far; the final bit is merged in on the last edge.
  logic [WIDTH-2:0] result_sr;
  logic             parity_acc;
  logic [CW-1:0]    cnt;
  logic             last;

  logic             any_req_c;
  logic             win1_c;
  logic             xor_bit_c;
  logic [WIDTH-1:0] sr_shift_c;
  logic             last_bit_c;

  logic gnt0_nxt;
  logic gnt1_nxt;
  logic busy_nxt;
  logic done_nxt;

  // Arbitration: a lone request wins; on a tie the requester that was not
  // served last wins.
  assign any_req_c = req0 | req1;
  assign win1_c    = req1 & (~req0 | ~last);

  // The shared single-bit XOR cell.
  assign xor_bit_c  = op_a[cnt] ^ op_b[cnt];
  assign sr_shift_c = {xor_bit_c, result_sr};
  assign last_bit_c = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req_c) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit_c) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode, computed one cycle ahead so the flags come from flops
  always_comb begin
    gnt0_nxt = 1'b0;
    gnt1_nxt = 1'b0;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
    if (state == ST_IDLE && any_req_c) begin
      gnt0_nxt = ~win1_c;
      gnt1_nxt = win1_c;
    end
  end

  // Output flag registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      gnt0 <= gnt0_nxt;
      gnt1 <= gnt1_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Operand capture, serial datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      result_sr  <= '0;
      parity_acc <= 1'b0;
      cnt        <= '0;
      last       <= 1'b1;
      result     <= '0;
      parity     <= 1'b0;
      done_id    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req_c) begin
            op_a       <= win1_c ? a1 : a0;
            op_b       <= win1_c ? b1 : b0;
            result_sr  <= '0;
            parity_acc <= 1'b0;
            cnt        <= '0;
            last       <= win1_c;
          end
        end
        ST_RUN: begin
          result_sr  <= sr_shift_c[WIDTH-1:1];
          parity_acc <= parity_acc ^ xor_bit_c;
          cnt        <= cnt + CW'(1);
          if (last_bit_c) begin
            result  <= sr_shift_c;
            parity  <= parity_acc ^ xor_bit_c;
            done_id <= last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_sched.sv
// Directed testbench for xor_share_sched (WIDTH = 8).
module tb_xor_share_sched;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;
  logic             parity;

  int n_vec;
  int n_err;

  xor_share_sched #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .parity  (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Called right after the grant cycle has been sampled; walks to done.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] exp_res,
                        input logic exp_par, input logic exp_id);
    for (int i = 1; i <= int'(WIDTH); i++) begin
      tick();
      if (i < int'(WIDTH)) begin
        if (done !== 1'b0 || busy !== 1'b1 || gnt0 !== 1'b0 || gnt1 !== 1'b0)
          check({tag, "_run_flags"}, {28'd0, done, busy, gnt0, gnt1}, 32'h4);
      end else begin
        check({tag, "_done"},    32'(done),    32'd1);
        check({tag, "_busy_d"},  32'(busy),    32'd1);
        check({tag, "_result"},  32'(result),  32'(exp_res));
        check({tag, "_parity"},  32'(parity),  32'(exp_par));
        check({tag, "_done_id"}, 32'(done_id), 32'(exp_id));
      end
    end
    tick();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"},     32'(busy), 32'd0);
    check({tag, "_hold"},     32'(result), 32'(exp_res));
  endtask

  int  gcyc [4];
  logic gid [4];
  int  ngr;
  logic bad;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req0 = 1'b0; a0 = '0; b0 = '0;
    req1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state
    tick();
    tick();
    check("rst_gnt0",    32'(gnt0),    32'd0);
    check("rst_gnt1",    32'(gnt1),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_result",  32'(result),  32'd0);
    check("rst_parity",  32'(parity),  32'd0);

    // 1: requester 0 alone, A5 ^ 0F = AA, even parity
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
    tick();
    check("t1_gnt0", 32'(gnt0), 32'd1);
    check("t1_gnt1", 32'(gnt1), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    req0 = 1'b0;
    run_op("t1", 8'hAA, 1'b0, 1'b0);

    // 2: requester 1 alone, 3C ^ 01 = 3D, odd parity
    req1 = 1'b1; a1 = 8'h3C; b1 = 8'h01;
    tick();
    check("t2_gnt1", 32'(gnt1), 32'd1);
    check("t2_gnt0", 32'(gnt0), 32'd0);
    req1 = 1'b0;
    run_op("t2", 8'h3D, 1'b1, 1'b1);

    // 3: both held from reset release -> 0,1,0 spaced WIDTH+2 cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    ngr = 0;
    bad = 1'b0;
    for (int c = 0; c <= 2 * (int'(WIDTH) + 2); c++) begin
      tick();
      if (gnt0 && gnt1) bad = 1'b1;
      if (done && (gnt0 || gnt1)) bad = 1'b1;
      if (gnt0 || gnt1) begin
        if (ngr < 4) begin
          gcyc[ngr] = c;
          gid[ngr]  = gnt1;
        end
        ngr++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t3_exclusive", 32'(bad), 32'd0);
    check("t3_ngrants",   32'(ngr), 32'd3);
    check("t3_g0_cyc", 32'(gcyc[0]), 32'd0);
    check("t3_g0_id",  32'(gid[0]),  32'd0);
    check("t3_g1_cyc", 32'(gcyc[1]), 32'(WIDTH + 2));
    check("t3_g1_id",  32'(gid[1]),  32'd1);
    check("t3_g2_cyc", 32'(gcyc[2]), 32'(2 * (WIDTH + 2)));
    check("t3_g2_id",  32'(gid[2]),  32'd0);

    // 4: reset during RUN aborts the operation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
    tick();
    check("t4_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    repeat (4) tick();
    check("t4_busy_run", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t4_busy",    32'(busy),    32'd0);
    check("t4_done",    32'(done),    32'd0);
    check("t4_gnt",     32'({gnt1, gnt0}), 32'd0);
    check("t4_result",  32'(result),  32'd0);
    check("t4_parity",  32'(parity),  32'd0);
    check("t4_done_id", 32'(done_id), 32'd0);
    bad = 1'b0;
    repeat (12) begin
      tick();
      if (done || gnt0 || gnt1 || busy) bad = 1'b1;
    end
    check("t4_no_ghost", 32'(bad), 32'd0);
    req1 = 1'b1; a1 = 8'h3C; b1 = 8'h01;
    tick();
    check("t4_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    run_op("t4", 8'h3D, 1'b1, 1'b1);

    // 5: operand change after grant does not affect the result
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
    tick();
    check("t5_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; a0 = 8'hFF;
    run_op("t5", 8'hAA, 1'b0, 1'b0);

    // 6: short req0 pulse during RUN is never granted
    req1 = 1'b1; a1 = 8'h3C; b1 = 8'h01;
    tick();
    check("t6_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    tick();
    tick();
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    check("t6_hold_result", 32'(result),  32'h0000_00AA);
    check("t6_hold_id",     32'(done_id), 32'd0);
    check("t6_no_gnt0",     32'(gnt0),    32'd0);
    bad = 1'b0;
    for (int i = 4; i < int'(WIDTH); i++) begin
      tick();
      if (gnt0 || done) bad = 1'b1;
    end
    check("t6_quiet_run", 32'(bad), 32'd0);
    tick();
    check("t6_done",    32'(done),    32'd1);
    check("t6_result",  32'(result),  32'h0000_003D);
    check("t6_parity",  32'(parity),  32'd1);
    check("t6_done_id", 32'(done_id), 32'd1);
    bad = 1'b0;
    repeat (12) begin
      tick();
      if (gnt0 || gnt1) bad = 1'b1;
    end
    check("t6_no_late_gnt", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xor_share_sched.md
Name: xor_share_sched

Overview:
- Round-robin scheduler that shares one bit-serial XOR datapath cell between two requesters.
- Each requester presents a pair of WIDTH-bit operands. The block grants one requester, captures its operands, and steps the shared single-bit XOR cell across the word LSB-first, one bit per clock.
- It returns the XOR word plus its parity, tagged with the served requester.
- It sits between client logic and the shared XOR cell (one instance, structural), replacing a per-client WIDTH-wide XOR array.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req0  input  1  requester 0 request; held high until gnt0.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request; held high until gnt1.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt0  output  1  one-cycle pulse: requester 0 operands captured.
- gnt1  output  1  one-cycle pulse: requester 1 operands captured.
- busy  output  1  high while an operation is in RUN or DONE.
- done  output  1  one-cycle pulse: result/parity/done_id valid.
- done_id  output  1  requester served by the completed operation (0 or 1).
- result  output  WIDTH  a XOR b of the served requester.
- parity  output  1  XOR-reduction of result (1 = odd number of ones).

Behaviour:

Reset:
- rst_n low at a rising edge sets state=IDLE.
- gnt0=gnt1=busy=done=0, done_id=0, result=0, parity=0, bit counter=0.
- Round-robin pointer last=1, so requester 0 wins first.
- Reset has priority over every other event, including mid-RUN. The in-flight operation is discarded; no done and no grant are issued for it.

States: IDLE, RUN, DONE.

IDLE:
- At an edge with req0|req1 high: choose a winner and latch a/b of the winner into internal op registers.
- At the same edge: clear the shift register and parity accumulator, set counter=0, set last=winner, assert gnt_winner for exactly the next cycle, go to RUN.
- Winner selection: if only one request is high, that requester wins. If both are high, the requester != last wins.
- No request: stay in IDLE, all pulses 0.

RUN:
- Each edge: bit = opA[cnt] ^ opB[cnt], computed by the shared 1-bit XOR cell.
- The bit shifts into result_sr from the MSB side (LSB-first fill). parity_acc ^= bit; cnt += 1.
- On the edge where cnt == WIDTH-1 is processed: go to DONE and copy result_sr, parity_acc and last into result, parity and done_id.
- Requests are ignored during RUN; operand inputs may change freely after the grant.

DONE:
- done=1 for exactly this cycle; go to IDLE on the next edge.
- Requests seen at this edge are NOT granted. Arbitration resumes in IDLE.

Timing:
- Grant edge E0 → gnt high in cycle E0..E1.
- done high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after gnt.
- Sustained throughput: one operation per WIDTH+2 cycles.

Outputs and flags:
- result, parity and done_id hold their last completed values until the next completion or reset.
- busy is high from the cycle after the grant edge through the DONE cycle inclusive.
- busy is 0 in IDLE, including the gnt cycle? No: busy=1 during the gnt cycle, since state is RUN.

Boundary conditions:
- Request dropped before grant: no grant, nothing captured.
- Both requesters held continuously: grants alternate 0,1,0,1…
- Single requester held continuously: it is granted every WIDTH+2 cycles.
- Counter wrap: cnt returns to 0 only via a new grant.
- gnt0 and gnt1 are never high together.
- done and gnt are never high in the same cycle.

Test Plan:
1. Reset, then req0=1, a0=8'hA5, b0=8'h0F, req1=0 → gnt0 pulse 1 cycle; 8 cycles later done=1, result=8'hAA, parity=0, done_id=0; busy low afterwards.
2. req1 only, a1=8'h3C, b1=8'h01 → gnt1; done with result=8'h3D, parity=1, done_id=1.
3. After reset, req0 and req1 high in the same cycle and held → gnt0 first, then gnt1. Third grant goes to 0. Grant spacing is 10 cycles for WIDTH=8.
4. rst_n driven low at RUN bit 4 of an operation → next cycle all outputs 0; no done for the aborted op. Next request served normally with the correct result.
5. Operands changed the cycle after gnt0 (a0=8'hFF) → result still reflects the captured values 8'hA5^8'h0F=8'hAA.
6. req0 pulsed for 1 cycle while state=RUN, then dropped → no gnt0 for it. done_id/result from the prior op are unchanged until the next completion.
